// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and one carry flop process
// A + B + C_in LSB first, one bit per clock, with a registered result.
module bit_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             ovf
);

   localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic             accept, sum_bit, carry_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_comb begin
      accept   = start && (state_q != RUN);
      sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
      carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = A;
         b_d     = B;
         sum_d   = '0;
         carry_d = C_in;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         // shift form keeps WIDTH=1 legal (no reversed part-select)
         sum_d   = (sum_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
         carry_d = carry_nx;
         cnt_d   = cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            s_d    = sum_d;
            cout_d = carry_nx;
            ovf_d  = carry_q ^ carry_nx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign S     = s_q;
   assign C_out = cout_q;
   assign ovf   = ovf_q;

endmodule
